// File: rtl/rvfi_order_sequencer_if.sv
// Bundle carrying the multi-channel RVFI retirement inputs and the serialized
// valid/ready output stream of rvfi_order_sequencer.
interface rvfi_order_sequencer_if #(
  parameter int XLEN = 32,
  parameter int NRET = 2
);
  logic [NRET-1:0]      rvfi_valid;
  logic [NRET*8-1:0]    rvfi_order;
  logic [NRET*32-1:0]   rvfi_insn;
  logic [NRET-1:0]      rvfi_trap;
  logic [NRET*XLEN-1:0] rvfi_pc_rdata;
  logic [NRET*XLEN-1:0] rvfi_pc_wdata;

  logic                 out_valid;
  logic                 out_ready;
  logic [7:0]           out_order;
  logic [31:0]          out_insn;
  logic                 out_trap;
  logic [XLEN-1:0]      out_pc_rdata;
  logic [XLEN-1:0]      out_pc_wdata;

  modport master (
    output rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_pc_rdata, rvfi_pc_wdata,
    output out_ready,
    input  out_valid, out_order, out_insn, out_trap, out_pc_rdata, out_pc_wdata
  );

  modport slave (
    input  rvfi_valid, rvfi_order, rvfi_insn, rvfi_trap, rvfi_pc_rdata, rvfi_pc_wdata,
    input  out_ready,
    output out_valid, out_order, out_insn, out_trap, out_pc_rdata, out_pc_wdata
  );
endinterface

// File: rtl/rvfi_order_sequencer.sv
// Reorders RVFI retirements from NRET channels into one strictly order-sequenced
// stream, using an order-indexed slot buffer of DEPTH entries.
module rvfi_order_sequencer #(
  parameter int XLEN  = 32,
  parameter int NRET  = 2,
  parameter int DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  rvfi_order_sequencer_if.slave bus,
  output logic                  err_window,
  output logic                  err_dup
);
  localparam int IDXW = $clog2(DEPTH);
  localparam logic [7:0] DEPTH_W = 8'(DEPTH);

  logic [DEPTH-1:0] occ;
  logic [7:0]       slot_order    [DEPTH];
  logic [31:0]      slot_insn     [DEPTH];
  logic             slot_trap     [DEPTH];
  logic [XLEN-1:0]  slot_pc_rdata [DEPTH];
  logic [XLEN-1:0]  slot_pc_wdata [DEPTH];

  logic [7:0]       next_order;
  logic [IDXW-1:0]  head;
  logic             load;

  logic [7:0]       ch_order [NRET];
  logic [7:0]       ch_dist  [NRET];
  logic [IDXW-1:0]  ch_idx   [NRET];
  logic [NRET-1:0]  ch_win_err;
  logic [NRET-1:0]  ch_dup_err;
  logic [NRET-1:0]  ch_accept;

  assign head = next_order[IDXW-1:0];
  assign load = (!bus.out_valid || bus.out_ready) && occ[head];

  // Lower channels are resolved first so they win any same-slot collision.
  always_comb begin
    for (int c = 0; c < NRET; c++) begin
      ch_order[c]   = bus.rvfi_order[c*8 +: 8];
      ch_dist[c]    = ch_order[c] - next_order;
      ch_idx[c]     = ch_order[c][IDXW-1:0];
      ch_win_err[c] = 1'b0;
      ch_dup_err[c] = 1'b0;
      ch_accept[c]  = 1'b0;
    end
    for (int c = 0; c < NRET; c++) begin
      if (bus.rvfi_valid[c]) begin
        if (ch_dist[c] >= DEPTH_W) begin
          ch_win_err[c] = 1'b1;
        end else begin
          ch_dup_err[c] = occ[ch_idx[c]];
          for (int p = 0; p < c; p++) begin
            if (ch_accept[p] && (ch_idx[p] == ch_idx[c])) ch_dup_err[c] = 1'b1;
          end
          ch_accept[c] = !ch_dup_err[c];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ              <= '0;
      next_order       <= '0;
      bus.out_valid    <= 1'b0;
      bus.out_order    <= '0;
      bus.out_insn     <= '0;
      bus.out_trap     <= 1'b0;
      bus.out_pc_rdata <= '0;
      bus.out_pc_wdata <= '0;
      err_window       <= 1'b0;
      err_dup          <= 1'b0;
    end else begin
      for (int c = 0; c < NRET; c++) begin
        if (ch_accept[c]) occ[ch_idx[c]] <= 1'b1;
      end
      // An accepted insert can never target the head slot while it is loading.
      if (load) begin
        occ[head]        <= 1'b0;
        bus.out_valid    <= 1'b1;
        bus.out_order    <= slot_order[head];
        bus.out_insn     <= slot_insn[head];
        bus.out_trap     <= slot_trap[head];
        bus.out_pc_rdata <= slot_pc_rdata[head];
        bus.out_pc_wdata <= slot_pc_wdata[head];
        next_order       <= next_order + 8'd1;
      end else if (bus.out_ready) begin
        bus.out_valid    <= 1'b0;
      end
      if (|ch_win_err) err_window <= 1'b1;
      if (|ch_dup_err) err_dup    <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    for (int c = 0; c < NRET; c++) begin
      if (ch_accept[c]) begin
        slot_order[ch_idx[c]]    <= ch_order[c];
        slot_insn[ch_idx[c]]     <= bus.rvfi_insn[c*32 +: 32];
        slot_trap[ch_idx[c]]     <= bus.rvfi_trap[c];
        slot_pc_rdata[ch_idx[c]] <= bus.rvfi_pc_rdata[c*XLEN +: XLEN];
        slot_pc_wdata[ch_idx[c]] <= bus.rvfi_pc_wdata[c*XLEN +: XLEN];
      end
    end
  end
endmodule

// File: tb/tb_rvfi_order_sequencer.sv
// Randomized and directed bench for rvfi_order_sequencer: an order-keyed reference
// model feeds an expected-output queue that a negedge monitor drains and compares.
module tb_rvfi_order_sequencer;
  localparam int XLEN  = 32;
  localparam int NRET  = 2;
  localparam int DEPTH = 8;

  typedef struct {
    logic [7:0]      order;
    logic [31:0]     insn;
    logic            trap;
    logic [XLEN-1:0] pc_rdata;
    logic [XLEN-1:0] pc_wdata;
  } entry_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic err_window;
  logic err_dup;

  rvfi_order_sequencer_if #(.XLEN(XLEN), .NRET(NRET)) bus ();

  rvfi_order_sequencer #(.XLEN(XLEN), .NRET(NRET), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .err_window (err_window),
    .err_dup    (err_dup)
  );

  always #5 clk = ~clk;

  int         n_vec = 0;
  int         n_err = 0;
  bit         mon_en = 1'b0;

  // Reference model: pending entries keyed by full 8-bit order.
  entry_t     exp_q[$];
  entry_t     m_buf [256];
  bit         m_pend [256];
  logic [7:0] m_next;
  bit         m_ov, m_ew, m_ed;

  bit         drv_v [NRET];
  entry_t     drv_e [NRET];

  function automatic void check_output(string name, logic [127:0] act, logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [127:0] pack(entry_t e);
    return {23'd0, e.order, e.insn, e.trap, e.pc_rdata, e.pc_wdata};
  endfunction

  function automatic entry_t make_entry(logic [7:0] order);
    entry_t e;
    e.order    = order;
    e.insn     = $urandom;
    e.trap     = ($urandom_range(0, 7) == 0);
    e.pc_rdata = XLEN'(32'h100 + {22'd0, order, 2'b00});
    e.pc_wdata = e.pc_rdata + XLEN'(4);
    return e;
  endfunction

  function automatic entry_t bus_entry(int c);
    entry_t e;
    e.order    = bus.rvfi_order[c*8 +: 8];
    e.insn     = bus.rvfi_insn[c*32 +: 32];
    e.trap     = bus.rvfi_trap[c];
    e.pc_rdata = bus.rvfi_pc_rdata[c*XLEN +: XLEN];
    e.pc_wdata = bus.rvfi_pc_wdata[c*XLEN +: XLEN];
    return e;
  endfunction

  // Advances the model across one clock edge using the inputs that edge saw.
  function automatic void model_step();
    bit         taken [256];
    bit         acc [NRET];
    entry_t     ins [NRET];
    entry_t     e;
    logic [7:0] d;
    bit         load;
    if (reset) begin
      m_next = 8'd0;
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_ov = 1'b0;
      m_ew = 1'b0;
      m_ed = 1'b0;
      exp_q.delete();
      return;
    end
    foreach (taken[i]) taken[i] = 1'b0;
    for (int c = 0; c < NRET; c++) begin
      acc[c] = 1'b0;
      if (bus.rvfi_valid[c]) begin
        e = bus_entry(c);
        d = e.order - m_next;
        if (int'(d) >= DEPTH) m_ew = 1'b1;
        else if (m_pend[e.order] || taken[e.order]) m_ed = 1'b1;
        else begin
          acc[c] = 1'b1;
          taken[e.order] = 1'b1;
          ins[c] = e;
        end
      end
    end
    load = (!m_ov || bus.out_ready) && m_pend[m_next];
    if (load) begin
      exp_q.push_back(m_buf[m_next]);
      m_pend[m_next] = 1'b0;
      m_next = m_next + 8'd1;
      m_ov = 1'b1;
    end else if (m_ov && bus.out_ready) begin
      m_ov = 1'b0;
    end
    for (int c = 0; c < NRET; c++) begin
      if (acc[c]) begin
        m_pend[ins[c].order] = 1'b1;
        m_buf[ins[c].order]  = ins[c];
      end
    end
  endfunction

  task automatic apply_stimulus(input bit rdy);
    for (int c = 0; c < NRET; c++) begin
      bus.rvfi_valid[c]                   = drv_v[c];
      bus.rvfi_order[c*8 +: 8]            = drv_e[c].order;
      bus.rvfi_insn[c*32 +: 32]           = drv_e[c].insn;
      bus.rvfi_trap[c]                    = drv_e[c].trap;
      bus.rvfi_pc_rdata[c*XLEN +: XLEN]   = drv_e[c].pc_rdata;
      bus.rvfi_pc_wdata[c*XLEN +: XLEN]   = drv_e[c].pc_wdata;
    end
    bus.out_ready = rdy;
    @(posedge clk);
    #1;
    model_step();
    for (int c = 0; c < NRET; c++) drv_v[c] = 1'b0;
  endtask

  task automatic put(input int c, input logic [7:0] o);
    drv_v[c] = 1'b1;
    drv_e[c] = make_entry(o);
  endtask

  task automatic idle(input int n, input bit rdy);
    repeat (n) apply_stimulus(rdy);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int c = 0; c < NRET; c++) begin
      drv_v[c] = 1'b0;
      drv_e[c] = make_entry(8'd0);
    end
    apply_stimulus(1'b1);
    reset  = 1'b0;
    mon_en = 1'b1;
  endtask

  // Monitor: pops the expected queue on each accepted transfer and checks stalls.
  entry_t cur, held, popped;
  bit     held_v = 1'b0;

  always @(negedge clk) begin
    if (reset || !mon_en) begin
      held_v = 1'b0;
    end else begin
      cur.order    = bus.out_order;
      cur.insn     = bus.out_insn;
      cur.trap     = bus.out_trap;
      cur.pc_rdata = bus.out_pc_rdata;
      cur.pc_wdata = bus.out_pc_wdata;
      check_output("out_valid", bus.out_valid, m_ov);
      check_output("err_flags", {err_window, err_dup}, {m_ew, m_ed});
      if (held_v) check_output("stall_stable", {bus.out_valid, pack(cur)}, {1'b1, pack(held)});
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check_output("expected_entry_available", exp_q.size(), 1);
        end else begin
          popped = exp_q.pop_front();
          check_output("out_order", cur.order, popped.order);
          check_output("out_payload", pack(cur), pack(popped));
        end
      end
      held_v = bus.out_valid && !bus.out_ready;
      held   = cur;
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] gen;
    logic [7:0] pool[$];
    logic [7:0] o;
    logic [7:0] d;
    int         idx;
    int         k;
    entry_t     e3;

    // In-order single channel, reset values and two-cycle latency.
    do_reset();
    check_output("reset_out_valid", bus.out_valid, 1'b0);
    check_output("reset_out_regs", {bus.out_order, bus.out_insn, bus.out_pc_rdata}, '0);
    check_output("reset_errs", {err_window, err_dup}, 2'b00);
    put(0, 8'd0); apply_stimulus(1'b1);
    check_output("latency_c1", bus.out_valid, 1'b0);
    put(0, 8'd1); apply_stimulus(1'b1);
    check_output("latency_c2", {bus.out_valid, bus.out_order}, {1'b1, 8'd0});
    put(0, 8'd2); apply_stimulus(1'b1);
    check_output("inorder_1", {bus.out_valid, bus.out_order}, {1'b1, 8'd1});
    put(0, 8'd3); apply_stimulus(1'b1);
    check_output("inorder_2", {bus.out_valid, bus.out_order}, {1'b1, 8'd2});
    apply_stimulus(1'b1);
    check_output("inorder_3", {bus.out_valid, bus.out_order}, {1'b1, 8'd3});
    idle(2, 1'b1);

    // Swapped channels in a single cycle.
    do_reset();
    put(0, 8'd1); put(1, 8'd0); apply_stimulus(1'b1);
    apply_stimulus(1'b1);
    check_output("swap_first", {bus.out_order, bus.out_pc_rdata}, {8'd0, 32'h100});
    apply_stimulus(1'b1);
    check_output("swap_second", {bus.out_order, bus.out_pc_rdata}, {8'd1, 32'h104});
    idle(2, 1'b1);

    // Backpressure holds order 5 stable for three cycles.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      put(0, 8'(i));
      apply_stimulus(1'b1);
    end
    put(0, 8'd5); put(1, 8'd6); apply_stimulus(1'b1);
    k = 0;
    while (!(bus.out_valid && bus.out_order == 8'd5) && k < 10) begin
      apply_stimulus(1'b1);
      k++;
    end
    check_output("bp_reach_5", {bus.out_valid, bus.out_order}, {1'b1, 8'd5});
    repeat (3) begin
      apply_stimulus(1'b0);
      check_output("bp_hold", {bus.out_valid, bus.out_order, bus.out_pc_rdata}, {1'b1, 8'd5, 32'h114});
    end
    apply_stimulus(1'b1);
    check_output("bp_next_6", {bus.out_valid, bus.out_order}, {1'b1, 8'd6});
    idle(3, 1'b1);

    // Window overflow: order 8 rejected, order 0 still flows.
    do_reset();
    put(0, 8'd8); apply_stimulus(1'b1);
    check_output("win_err_set", {err_window, err_dup}, 2'b10);
    put(0, 8'd0); apply_stimulus(1'b1);
    apply_stimulus(1'b1);
    check_output("win_order0", {bus.out_valid, bus.out_order}, {1'b1, 8'd0});
    idle(3, 1'b1);
    check_output("win_no_issue", {bus.out_valid, err_window}, 2'b01);

    // Duplicate order on both channels: channel 0 wins.
    do_reset();
    put(0, 8'd0); put(1, 8'd1); apply_stimulus(1'b1);
    put(0, 8'd2); apply_stimulus(1'b1);
    put(0, 8'd3); put(1, 8'd3); e3 = drv_e[0]; apply_stimulus(1'b1);
    check_output("dup_err_set", {err_window, err_dup}, 2'b01);
    k = 0;
    while (!(bus.out_valid && bus.out_order == 8'd3) && k < 8) begin
      apply_stimulus(1'b1);
      k++;
    end
    check_output("dup_ch0_wins", {bus.out_valid, bus.out_insn}, {1'b1, e3.insn});
    idle(2, 1'b1);

    // Wrap-around of the 8-bit order through 254, 255, 0, 1.
    do_reset();
    for (int i = 0; i < 254; i++) begin
      put(0, 8'(i));
      apply_stimulus(1'b1);
    end
    idle(3, 1'b1);
    put(0, 8'd255); put(1, 8'd254); apply_stimulus(1'b1);
    put(0, 8'd1); put(1, 8'd0); apply_stimulus(1'b1);
    check_output("wrap_254", {bus.out_valid, bus.out_order}, {1'b1, 8'd254});
    apply_stimulus(1'b1);
    check_output("wrap_255", {bus.out_valid, bus.out_order}, {1'b1, 8'd255});
    apply_stimulus(1'b1);
    check_output("wrap_0", {bus.out_valid, bus.out_order}, {1'b1, 8'd0});
    apply_stimulus(1'b1);
    check_output("wrap_1", {bus.out_valid, bus.out_order}, {1'b1, 8'd1});
    idle(2, 1'b1);
    check_output("wrap_errs", {err_window, err_dup}, 2'b00);

    // Reset mid-stream with a stalled output and four buffered entries.
    do_reset();
    put(0, 8'd8); apply_stimulus(1'b0);
    for (int i = 0; i < 5; i++) begin
      put(0, 8'(i));
      apply_stimulus(1'b0);
    end
    check_output("pre_reset_state", {bus.out_valid, bus.out_order, err_window}, {1'b1, 8'd0, 1'b1});
    do_reset();
    check_output("mid_reset_clear", {bus.out_valid, err_window, err_dup, bus.out_order}, '0);
    put(0, 8'd0); apply_stimulus(1'b1);
    apply_stimulus(1'b1);
    check_output("post_reset_0", {bus.out_valid, bus.out_order, bus.out_pc_rdata}, {1'b1, 8'd0, 32'h100});
    apply_stimulus(1'b1);
    check_output("post_reset_no_stale", bus.out_valid, 1'b0);

    // Randomized out-of-order traffic with random backpressure, then error injection.
    do_reset();
    gen = 8'd0;
    for (int cyc = 0; cyc < 900; cyc++) begin
      while (pool.size() < 6) begin
        pool.push_back(gen);
        gen = gen + 8'd1;
      end
      for (int c = 0; c < NRET; c++) begin
        if ($urandom_range(0, 9) < 7) begin
          idx = $urandom_range(0, 3);
          if (idx < pool.size()) begin
            o = pool[idx];
            d = o - m_next;
            if (int'(d) < DEPTH) begin
              put(c, o);
              pool.delete(idx);
            end
          end
        end
      end
      if (cyc >= 750 && $urandom_range(0, 19) == 0) put($urandom_range(0, 1), 8'($urandom));
      apply_stimulus($urandom_range(0, 3) != 0);
    end
    idle(12, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
